store_queue_mp: RTL and testbench

Parametrised multi-port store queue: N-wide dispatch/retire, out-of-order address/data resolution, per-byte store-to-load forwarding to several load ports, and an in-order drain of retired stores to the D-cache over a valid/ready handshake. Sits between dispatch, the store unit, the load units, the branch stack, retire and the D-cache. Unlike the single-port queue, it flags loads that pass an older store with an unresolved address.

---
 rtl/store_queue_mp_pkg.sv | 21 ++
 rtl/sq_youngest_sel.sv | 32 +++
 rtl/store_queue_mp.sv | 157 +++++++++++++++
 tb/tb_store_queue_mp.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_queue_mp_pkg.sv
// Shared types and defaults for the multi-port store queue.
package store_queue_mp_pkg;

  localparam int unsigned SQ_DEPTH_DEF = 8;
  localparam int unsigned SQ_IDX_W_DEF = $clog2(SQ_DEPTH_DEF);

  typedef logic [3:0] byte_mask_t;

  typedef struct packed {
    logic                    wrap;
    logic [SQ_IDX_W_DEF-1:0] idx;
  } sq_ptr_t;

  typedef struct packed {
    logic       addr_valid;
    logic [31:0] addr;
    logic [31:0] data;
    byte_mask_t bmask;
  } sq_entry_t;

endpackage

// File: rtl/sq_youngest_sel.sv
// Picks the youngest requesting entry older than tail_idx_i (circular order).
module sq_youngest_sel #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req_i,
  input  logic [IDX_W-1:0] tail_idx_i,
  output logic             found_o,
  output logic [IDX_W-1:0] sel_o
);

  // rot[k] is the entry k+1 positions older than the tail
  logic [DEPTH-1:0] rot;

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      rot[k] = req_i[IDX_W'(tail_idx_i - IDX_W'(k) - IDX_W'(1))];
    end
  end

  always_comb begin
    found_o = 1'b0;
    sel_o   = '0;
    for (int unsigned k = DEPTH; k > 0; k--) begin
      if (rot[k-1]) begin
        found_o = 1'b1;
        sel_o   = IDX_W'(tail_idx_i - IDX_W'(k));
      end
    end
  end

endmodule

// File: rtl/store_queue_mp.sv
// Multi-port store queue: N-wide dispatch/retire, OoO resolve, per-byte
// load forwarding with unresolved-address detection, in-order D-cache drain.
module store_queue_mp
  import store_queue_mp_pkg::*;
#(
  parameter int unsigned SQ_DEPTH   = SQ_DEPTH_DEF,
  parameter int unsigned DISPATCH_W = 3,
  parameter int unsigned RETIRE_W   = 3,
  parameter int unsigned LD_PORTS   = 2,
  localparam int unsigned IDX_W = $clog2(SQ_DEPTH),
  localparam int unsigned PTR_W = IDX_W + 1,
  localparam int unsigned DC_W  = $clog2(DISPATCH_W + 1),
  localparam int unsigned RC_W  = $clog2(RETIRE_W + 1)
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [DC_W-1:0]               disp_count_i,
  output logic [PTR_W-1:0]              sq_tail_o,
  output logic [DC_W-1:0]               sq_spots_o,
  input  logic                          res_valid_i,
  input  logic [PTR_W-1:0]              res_ptr_i,
  input  logic [31:0]                   res_addr_i,
  input  logic [31:0]                   res_data_i,
  input  byte_mask_t                    res_bmask_i,
  input  logic [LD_PORTS-1:0]           ld_valid_i,
  input  logic [LD_PORTS-1:0][31:0]     ld_addr_i,
  input  logic [LD_PORTS-1:0][PTR_W-1:0] ld_tail_i,
  output logic [LD_PORTS-1:0][31:0]     ld_data_o,
  output logic [LD_PORTS-1:0][3:0]      ld_fwd_mask_o,
  output logic [LD_PORTS-1:0]           ld_unknown_o,
  input  logic                          restore_valid_i,
  input  logic [PTR_W-1:0]              restore_tail_i,
  input  logic [RC_W-1:0]               retire_count_i,
  output logic                          cache_valid_o,
  output logic [31:0]                   cache_addr_o,
  output logic [31:0]                   cache_data_o,
  output byte_mask_t                    cache_bmask_o,
  input  logic                          cache_ready_i
);

  sq_entry_t        ent_q [SQ_DEPTH];
  sq_entry_t        ent_d [SQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, commit_q, commit_d, tail_q, tail_d;
  logic [PTR_W-1:0] occ, free_cnt;
  logic             drain;

  assign occ        = PTR_W'(tail_q - head_q);
  assign free_cnt   = PTR_W'(PTR_W'(SQ_DEPTH) - occ);
  assign sq_spots_o = (32'(free_cnt) > DISPATCH_W) ? DC_W'(DISPATCH_W) : DC_W'(free_cnt);
  assign sq_tail_o  = tail_q;

  assign cache_valid_o = (head_q != commit_q);
  assign cache_addr_o  = ent_q[head_q[IDX_W-1:0]].addr;
  assign cache_data_o  = ent_q[head_q[IDX_W-1:0]].data;
  assign cache_bmask_o = ent_q[head_q[IDX_W-1:0]].bmask;
  assign drain         = cache_valid_o & cache_ready_i;

  always_comb begin
    ent_d    = ent_q;
    head_d   = PTR_W'(head_q + PTR_W'(drain));
    commit_d = PTR_W'(commit_q + PTR_W'(retire_count_i));
    tail_d   = tail_q;
    // A rollback overrides any dispatch presented in the same cycle
    if (restore_valid_i) begin
      tail_d = restore_tail_i;
    end else begin
      tail_d = PTR_W'(tail_q + PTR_W'(disp_count_i));
      for (int unsigned k = 0; k < DISPATCH_W; k++) begin
        if (k < 32'(disp_count_i)) begin
          ent_d[IDX_W'(tail_q[IDX_W-1:0] + IDX_W'(k))].addr_valid = 1'b0;
        end
      end
    end
    if (res_valid_i) begin
      ent_d[res_ptr_i[IDX_W-1:0]] = '{addr_valid: 1'b1, addr: res_addr_i,
                                      data: res_data_i, bmask: res_bmask_i};
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      for (int unsigned i = 0; i < SQ_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      ent_q    <= ent_d;
    end
  end

  logic retire_ok_c, restore_ok_c;

  always_comb begin
    retire_ok_c = 1'b1;
    for (int unsigned k = 0; k < RETIRE_W; k++) begin
      if (k < 32'(retire_count_i) &&
          !ent_q[IDX_W'(commit_q[IDX_W-1:0] + IDX_W'(k))].addr_valid) begin
        retire_ok_c = 1'b0;
      end
    end
  end

  assign restore_ok_c = !restore_valid_i ||
                        (PTR_W'(restore_tail_i - head_q) >= PTR_W'(commit_d - head_q));

  always @(posedge clock_i) begin
    if (!reset_i) begin
      assert (retire_ok_c) else $error("store_queue_mp: retiring a store with unresolved address");
      assert (restore_ok_c) else $error("store_queue_mp: restore_tail older than commit");
    end
  end

  logic                    unused_res_wrap;
  logic [2*LD_PORTS-1:0]   unused_ld_lo;
  assign unused_res_wrap = res_ptr_i[IDX_W];

  for (genvar p = 0; p < LD_PORTS; p++) begin : g_ld
    logic [PTR_W-1:0]          span;
    logic [SQ_DEPTH-1:0]       in_rng, unres;
    logic [3:0][SQ_DEPTH-1:0]  req;
    logic [3:0]                found;
    logic [3:0][IDX_W-1:0]     sel;

    assign unused_ld_lo[2*p +: 2] = ld_addr_i[p][1:0];
    assign span = PTR_W'(ld_tail_i[p] - head_q);

    // Age window is [head, ld_tail) measured relative to head
    always_comb begin
      for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
        in_rng[i] = ld_valid_i[p] && (32'(span) <= SQ_DEPTH) &&
                    (32'(IDX_W'(IDX_W'(i) - head_q[IDX_W-1:0])) < 32'(span));
        unres[i]  = in_rng[i] && !ent_q[i].addr_valid;
        for (int unsigned b = 0; b < 4; b++) begin
          req[b][i] = in_rng[i] && ent_q[i].addr_valid && ent_q[i].bmask[b] &&
                      (ent_q[i].addr[31:2] == ld_addr_i[p][31:2]);
        end
      end
    end

    assign ld_unknown_o[p] = |unres;

    for (genvar b = 0; b < 4; b++) begin : g_byte
      sq_youngest_sel #(.DEPTH(SQ_DEPTH), .IDX_W(IDX_W)) u_sel (
        .req_i      (req[b]),
        .tail_idx_i (ld_tail_i[p][IDX_W-1:0]),
        .found_o    (found[b]),
        .sel_o      (sel[b])
      );
      assign ld_data_o[p][8*b +: 8] = found[b] ? ent_q[sel[b]].data[8*b +: 8] : 8'h00;
      assign ld_fwd_mask_o[p][b]    = found[b];
    end
  end

endmodule

// File: tb/tb_store_queue_mp.sv
// Bench for store_queue_mp: directed scenarios then random traffic against
// a sequence-number based model of the queue.
module tb_store_queue_mp;

  localparam int DEPTH = 8;
  localparam int PTR_W = 4;
  localparam int DW    = 3;
  localparam int RW    = 3;
  localparam int NP    = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [1:0]               disp_count;
  logic [PTR_W-1:0]         sq_tail;
  logic [1:0]               sq_spots;
  logic                     res_valid;
  logic [PTR_W-1:0]         res_ptr;
  logic [31:0]              res_addr, res_data;
  logic [3:0]               res_bmask;
  logic [NP-1:0]            ld_valid;
  logic [NP-1:0][31:0]      ld_addr;
  logic [NP-1:0][PTR_W-1:0] ld_tail;
  logic [NP-1:0][31:0]      ld_data;
  logic [NP-1:0][3:0]       ld_fwd_mask;
  logic [NP-1:0]            ld_unknown;
  logic                     restore_valid;
  logic [PTR_W-1:0]         restore_tail;
  logic [1:0]               retire_count;
  logic                     cache_valid;
  logic [31:0]              cache_addr, cache_data;
  logic [3:0]               cache_bmask;
  logic                     cache_ready;

  always #5 clock = ~clock;

  store_queue_mp dut (
    .clock_i(clock), .reset_i(reset), .disp_count_i(disp_count),
    .sq_tail_o(sq_tail), .sq_spots_o(sq_spots),
    .res_valid_i(res_valid), .res_ptr_i(res_ptr), .res_addr_i(res_addr),
    .res_data_i(res_data), .res_bmask_i(res_bmask),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_tail_i(ld_tail),
    .ld_data_o(ld_data), .ld_fwd_mask_o(ld_fwd_mask), .ld_unknown_o(ld_unknown),
    .restore_valid_i(restore_valid), .restore_tail_i(restore_tail),
    .retire_count_i(retire_count),
    .cache_valid_o(cache_valid), .cache_addr_o(cache_addr), .cache_data_o(cache_data),
    .cache_bmask_o(cache_bmask), .cache_ready_i(cache_ready)
  );

  // Model: stores indexed by absolute sequence number, pointers never wrap
  typedef struct {
    logic        resolved;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bmask;
  } st_t;

  st_t mem [0:4095];
  int  head_a, commit_a, tail_a;
  int  res_abs, restore_abs;
  int  ld_tail_a [NP];
  int  total = 0;
  int  bad   = 0;
  logic [31:0] pool [3] = '{32'h100, 32'h104, 32'h200};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    head_a = 0; commit_a = 0; tail_a = 0;
    for (int i = 0; i < 4096; i++) mem[i].resolved = 1'b0;
    for (int p = 0; p < NP; p++) ld_tail_a[p] = 0;
  endtask

  task automatic exp_load(input int p, output logic [31:0] d, output logic [3:0] m,
                          output logic u);
    d = '0; m = '0; u = 1'b0;
    if (ld_valid[p]) begin
      for (int s = ld_tail_a[p] - 1; s >= head_a; s--) begin
        if (!mem[s].resolved) u = 1'b1;
        else if (mem[s].addr[31:2] == ld_addr[p][31:2]) begin
          for (int b = 0; b < 4; b++) begin
            if (mem[s].bmask[b] && !m[b]) begin
              m[b] = 1'b1;
              d[8*b +: 8] = mem[s].data[8*b +: 8];
            end
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d;
    logic [3:0]  m;
    logic        u;
    int          sp;
    sp = DEPTH - (tail_a - head_a);
    if (sp > DW) sp = DW;
    chk({tag, ".sq_tail"}, 32'(sq_tail), 32'(tail_a % 16));
    chk({tag, ".sq_spots"}, 32'(sq_spots), 32'(sp));
    chk({tag, ".cache_valid"}, 32'(cache_valid), 32'(head_a < commit_a));
    if (head_a < commit_a) begin
      chk({tag, ".cache_addr"}, cache_addr, mem[head_a].addr);
      chk({tag, ".cache_data"}, cache_data, mem[head_a].data);
      chk({tag, ".cache_bmask"}, 32'(cache_bmask), 32'(mem[head_a].bmask));
    end
    for (int p = 0; p < NP; p++) begin
      exp_load(p, d, m, u);
      chk($sformatf("%s.ld%0d_data", tag, p), ld_data[p], d);
      chk($sformatf("%s.ld%0d_mask", tag, p), 32'(ld_fwd_mask[p]), 32'(m));
      chk($sformatf("%s.ld%0d_unknown", tag, p), 32'(ld_unknown[p]), 32'(u));
    end
  endtask

  task automatic set_load(input int p, input logic v, input logic [31:0] a, input int t);
    ld_valid[p] = v; ld_addr[p] = a; ld_tail_a[p] = t; ld_tail[p] = PTR_W'(t % 16);
  endtask

  task automatic resolve(input int abs, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
    res_valid = 1'b1; res_abs = abs; res_ptr = PTR_W'(abs % 16);
    res_addr = a; res_data = d; res_bmask = m;
  endtask

  task automatic do_restore(input int abs);
    restore_valid = 1'b1; restore_abs = abs; restore_tail = PTR_W'(abs % 16);
  endtask

  // Advance the model with the inputs currently driven, then clock the DUT
  task automatic step();
    logic drain;
    drain = (head_a < commit_a) && cache_ready;
    if (res_valid) begin
      mem[res_abs].resolved = 1'b1; mem[res_abs].addr = res_addr;
      mem[res_abs].data = res_data; mem[res_abs].bmask = res_bmask;
    end
    if (!restore_valid) begin
      for (int k = 0; k < int'(disp_count); k++) mem[tail_a + k].resolved = 1'b0;
      tail_a += int'(disp_count);
    end
    commit_a += int'(retire_count);
    if (drain) head_a++;
    if (restore_valid) tail_a = restore_abs;
    @(posedge clock);
    #1;
    disp_count = '0; res_valid = 1'b0; retire_count = '0; restore_valid = 1'b0;
  endtask

  task automatic step_check(input string tag);
    step();
    #1 check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; disp_count = '0; res_valid = 1'b0; res_ptr = '0; res_addr = '0;
    res_data = '0; res_bmask = '0; ld_valid = '0; ld_addr = '0; ld_tail = '0;
    restore_valid = 1'b0; restore_tail = '0; retire_count = '0; cache_ready = 1'b0;
    res_abs = 0; restore_abs = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1 check_all("reset");
    chk("reset_spots", 32'(sq_spots), 32'd3);

    // Unresolved older stores flag the load
    disp_count = 2'd3; step_check("disp3");
    resolve(1, 32'h100, 32'hAABBCCDD, 4'hF); step();
    set_load(0, 1'b1, 32'h100, 3);
    #1 check_all("unknown");
    chk("tp_unknown", 32'(ld_unknown[0]), 32'd1);

    // Per-byte merge from youngest matching stores
    resolve(0, 32'h200, 32'h55667788, 4'hF); step_check("res0");
    resolve(2, 32'h100, 32'h11223344, 4'h3); step_check("res2");
    chk("tp_fwd_data", ld_data[0], 32'hAABB3344);
    chk("tp_fwd_mask", 32'(ld_fwd_mask[0]), 32'hF);
    set_load(0, 1'b0, 32'h0, 0);

    // Fill to full, then retire one and watch the drain free a slot
    disp_count = 2'd3; step_check("fill_a");
    disp_count = 2'd2; step_check("fill_b");
    chk("tp_full_spots", 32'(sq_spots), 32'd0);
    for (int s = 3; s < 8; s++) begin
      resolve(s, 32'h104, $urandom, 4'hF); step_check("fill_res");
    end
    cache_ready = 1'b1; retire_count = 2'd1; step_check("ret1");
    chk("tp_cv_t1", 32'(cache_valid), 32'd1);
    chk("tp_spots_t1", 32'(sq_spots), 32'd0);
    step_check("drain1");
    chk("tp_spots_t2", 32'(sq_spots), 32'd1);

    // Restore with dispatch and retire in the same cycle
    cache_ready = 1'b0;
    disp_count = 2'd1; retire_count = 2'd2; do_restore(3); step_check("restore");
    chk("tp_restore_tail", 32'(sq_tail), 32'd3);
    cache_ready = 1'b1;
    step_check("drain_r1");
    step_check("drain_r2");

    // March stores through until the pointers wrap
    while (tail_a < 19) begin
      disp_count = 2'd1; step_check("wrap_disp");
      resolve(tail_a - 1, pool[$urandom_range(0, 2)], $urandom, 4'(1 + $urandom_range(0, 14)));
      step_check("wrap_res");
      retire_count = 2'd1; step_check("wrap_ret");
      step_check("wrap_drain");
    end
    cache_ready = 1'b0;
    disp_count = 2'd3; step_check("wfill_a");
    disp_count = 2'd3; step_check("wfill_b");
    disp_count = 2'd2; step_check("wfill_c");
    chk("tp_wrap_tail", 32'(sq_tail), 32'b1011);
    chk("tp_wrap_spots", 32'(sq_spots), 32'd0);
    for (int s = 19; s < 27; s++) begin
      resolve(s, 32'h300, $urandom, 4'(1 << (s % 4)) | 4'(s[0])); step_check("wfill_res");
    end
    set_load(0, 1'b1, 32'h300, 27);
    set_load(1, 1'b1, 32'h302, 24);
    #1 check_all("wrap_fwd");

    // Stall the drain; outputs must hold, then async reset mid-hold
    retire_count = 2'd1; step_check("hold_ret");
    for (int i = 0; i < 4; i++) step_check("hold");
    ld_valid = '0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_reset");
    chk("tp_rst_cv", 32'(cache_valid), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      int sp, maxr, rc;
      int cand[$];
      sp = DEPTH - (tail_a - head_a);
      if (sp > DW) sp = DW;
      disp_count = 2'($urandom_range(0, sp));
      cand.delete();
      for (int s = commit_a; s < tail_a; s++) if (!mem[s].resolved) cand.push_back(s);
      if (cand.size() > 0 && $urandom_range(0, 3) != 0)
        resolve(cand[$urandom_range(0, cand.size() - 1)],
                pool[$urandom_range(0, 2)] | 32'($urandom_range(0, 3)),
                $urandom, 4'(1 + $urandom_range(0, 14)));
      maxr = 0;
      while (maxr < RW && commit_a + maxr < tail_a && mem[commit_a + maxr].resolved) maxr++;
      rc = $urandom_range(0, maxr);
      retire_count = 2'(rc);
      if ($urandom_range(0, 15) == 0) do_restore($urandom_range(commit_a + rc, tail_a));
      cache_ready = ($urandom_range(0, 3) != 0);
      step();
      for (int p = 0; p < NP; p++)
        set_load(p, 1'($urandom_range(0, 3) != 0),
                 pool[$urandom_range(0, 2)] | 32'($urandom_range(0, 3)),
                 $urandom_range(head_a, tail_a));
      #1 check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
